// File: rtl/tone_det_pkg.sv
// +----------------------------------------------------------------------+
// | tone_det_pkg : shared types and constants for the tone detector       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package tone_det_pkg;

  typedef enum logic [1:0] {
    SEEK_LOW = 2'd0,
    LOW      = 2'd1,
    HIGH     = 2'd2
  } tone_det_state_t;

  typedef logic signed [15:0] sample_t;

  localparam sample_t HYST_DEFAULT = 16'sd1024;

  // 17-bit intermediate so that |-32768| is representable as 16'h8000
  function automatic logic [15:0] abs16(input sample_t x);
    logic signed [16:0] x17;
    logic signed [16:0] neg17;
    x17   = {x[15], x};
    neg17 = -x17;
    return x17[16] ? neg17[15:0] : x17[15:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/tone_det_crossing.sv
// +----------------------------------------------------------------------+
// | tone_det_crossing : hysteresis crossing FSM and reference flag        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tone_det_crossing
  import tone_det_pkg::*;
#(
  parameter sample_t HYST = HYST_DEFAULT
) (
  input  logic    clk,
  input  logic    rst_in,
  input  sample_t data_i,
  input  logic    valid_i,
  input  logic    cnt_sat_i,
  output logic    rising_event_o,
  output logic    timeout_clear_o,
  output logic    have_ref_o
);

  tone_det_state_t state_q;
  logic            have_ref_q;
  logic            is_high;
  logic            is_low;

  assign is_high         = (data_i >= HYST);
  assign is_low          = (data_i <= -HYST);
  assign rising_event_o  = valid_i && (state_q == LOW) && is_high;
  // An event on the saturating sample takes precedence over the timeout
  assign timeout_clear_o = valid_i && cnt_sat_i && !rising_event_o;
  assign have_ref_o      = have_ref_q;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q    <= SEEK_LOW;
      have_ref_q <= 1'b0;
    end else if (valid_i) begin
      if (rising_event_o) begin
        state_q    <= HIGH;
        have_ref_q <= 1'b1;
      end else if (timeout_clear_o) begin
        state_q    <= SEEK_LOW;
        have_ref_q <= 1'b0;
      end else begin
        case (state_q)
          SEEK_LOW: if (is_low) state_q <= LOW;
          HIGH:     if (is_low) state_q <= LOW;
          default:  state_q <= state_q;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tone_detector.sv
// +----------------------------------------------------------------------+
// | tone_detector : period / peak / lock measurement of a test tone       |
// | Optional peak tracker enabled by TONE_DET_PEAK_EN.  Rev 1.0           |
// +----------------------------------------------------------------------+
`default_nettype none

module tone_detector
  import tone_det_pkg::*;
#(
  parameter sample_t HYST       = HYST_DEFAULT,
  parameter int      PERIOD_W   = 16,
  parameter int      PERIOD_TOL = 2,
  parameter int      LOCK_COUNT = 4
) (
  input  logic                clk,
  input  logic                rst_in,
  input  logic signed [15:0]  data_in,
  input  logic                sample_valid_in,
  output logic [PERIOD_W-1:0] period_out,
  output logic [15:0]         peak_out,
  output logic                measure_valid_out,
  output logic                locked_out
);

  localparam int                  MATCH_W  = $clog2(LOCK_COUNT + 1);
  localparam logic [MATCH_W-1:0]  LOCK_N   = MATCH_W'(LOCK_COUNT);
  localparam logic [PERIOD_W-1:0] TOL      = PERIOD_W'(PERIOD_TOL);
  localparam logic [PERIOD_W-1:0] CNT_LAST = {{(PERIOD_W-1){1'b1}}, 1'b0};

  logic                rising_event;
  logic                timeout_clear;
  logic                have_ref;
  logic                measure;
  logic                cnt_sat;
  logic                match;
  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] period_d;
  logic [PERIOD_W-1:0] diff;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] prev_q;
  logic                prev_vld_q;
  logic [MATCH_W-1:0]  match_q;
  logic [MATCH_W-1:0]  match_d;
  logic                locked_q;
  logic                mv_q;

  tone_det_crossing #(
    .HYST (HYST)
  ) u_crossing (
    .clk             (clk),
    .rst_in          (rst_in),
    .data_i          (data_in),
    .valid_i         (sample_valid_in),
    .cnt_sat_i       (cnt_sat),
    .rising_event_o  (rising_event),
    .timeout_clear_o (timeout_clear),
    .have_ref_o      (have_ref)
  );

  // Timeout fires on the non-event sample that would bring cnt to all-ones
  assign cnt_sat  = (cnt_q == CNT_LAST);
  assign measure  = rising_event && have_ref;
  assign period_d = cnt_q + 1'b1;
  assign diff     = (period_d >= prev_q) ? (period_d - prev_q) : (prev_q - period_d);
  assign match    = prev_vld_q && (diff <= TOL);

  always_comb begin
    match_d = '0;
    if (match) match_d = (match_q == LOCK_N) ? LOCK_N : match_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_in || rising_event || timeout_clear) begin
      cnt_q <= '0;
    end else if (sample_valid_in) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      period_q   <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      match_q    <= '0;
      locked_q   <= 1'b0;
      mv_q       <= 1'b0;
    end else begin
      mv_q <= measure;
      if (timeout_clear) begin
        prev_vld_q <= 1'b0;
        match_q    <= '0;
        locked_q   <= 1'b0;
      end else if (measure) begin
        period_q   <= period_d;
        prev_q     <= period_d;
        prev_vld_q <= 1'b1;
        match_q    <= match_d;
        locked_q   <= (match_d == LOCK_N);
      end
    end
  end

`ifdef TONE_DET_PEAK_EN
  logic [15:0] abs_x;
  logic [15:0] trk_q;
  logic [15:0] peak_q;

  assign abs_x = abs16(data_in);

  // Captured peak excludes the event sample, which then seeds the tracker
  always_ff @(posedge clk) begin
    if (rst_in) begin
      trk_q  <= '0;
      peak_q <= '0;
    end else if (sample_valid_in) begin
      if (rising_event) begin
        trk_q <= abs_x;
        if (measure) peak_q <= trk_q;
      end else if (abs_x > trk_q) begin
        trk_q <= abs_x;
      end
    end
  end

  assign peak_out = peak_q;
`else
  assign peak_out = '0;
`endif

  assign period_out        = period_q;
  assign measure_valid_out = mv_q;
  assign locked_out        = locked_q;

endmodule

`default_nettype wire

// File: tb/tb_tone_detector.sv
// Directed self-checking bench for tone_detector.
`timescale 1ns/1ps
`default_nettype none

module tb_tone_detector;

  logic               clk = 1'b0;
  logic               rst_in = 1'b1;
  logic signed [15:0] data_in = '0;
  logic               sample_valid_in = 1'b0;
  logic [15:0]        period_out;
  logic [15:0]        peak_out;
  logic               measure_valid_out;
  logic               locked_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int sample_no = 0;
  int q_cyc[$];
  int q_smp[$];
  int q_per[$];
  int q_peak[$];
  int q_lock[$];

  logic signed [15:0] sine [8] = '{16'sh0000, 16'sh5A7E, 16'sh7FFF, 16'sh5A7E,
                                   16'sh0000, 16'shA582, 16'sh8000, 16'shA582};

`ifdef TONE_DET_PEAK_EN
  localparam int EXP_PEAK = 32768;
  localparam int SQ_PEAK  = 1024;
`else
  localparam int EXP_PEAK = 0;
  localparam int SQ_PEAK  = 0;
`endif

  tone_detector dut (
    .clk               (clk),
    .rst_in            (rst_in),
    .data_in           (data_in),
    .sample_valid_in   (sample_valid_in),
    .period_out        (period_out),
    .peak_out          (peak_out),
    .measure_valid_out (measure_valid_out),
    .locked_out        (locked_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (measure_valid_out) begin
      q_cyc.push_back(cyc);
      q_smp.push_back(sample_no);
      q_per.push_back(int'(period_out));
      q_peak.push_back(int'(peak_out));
      q_lock.push_back(int'(locked_out));
    end
  end

  task automatic drive(input logic signed [15:0] x, input logic v);
    @(negedge clk);
    data_in = x;
    sample_valid_in = v;
    if (v) sample_no++;
  endtask

  task automatic clear_log();
    q_cyc.delete(); q_smp.delete(); q_per.delete(); q_peak.delete(); q_lock.delete();
    sample_no = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_in = 1'b1; sample_valid_in = 1'b0;
    @(negedge clk); rst_in = 1'b0;
    clear_log();
  endtask

  task automatic run_tone(input int periods, input int hold, input bit sparse);
    for (int p = 0; p < periods; p++)
      for (int k = 0; k < 8; k++)
        for (int h = 0; h < hold; h++) begin
          drive(sine[k], 1'b1);
          if (sparse) drive(16'sh8000, 1'b0);
        end
  endtask

  task automatic test_reset();
    @(negedge clk); rst_in = 1'b1; sample_valid_in = 1'b1; data_in = 16'sh8000;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (period_out !== 16'd0) begin failures++; $display("FAIL reset_period got=%0d exp=0", period_out); end
    checks++; if (peak_out !== 16'd0) begin failures++; $display("FAIL reset_peak got=%0d exp=0", peak_out); end
    checks++; if (measure_valid_out !== 1'b0) begin failures++; $display("FAIL reset_mv got=%0b exp=0", measure_valid_out); end
    checks++; if (locked_out !== 1'b0) begin failures++; $display("FAIL reset_lock got=%0b exp=0", locked_out); end
    @(negedge clk); rst_in = 1'b0; sample_valid_in = 1'b0;
    clear_log();
  endtask

  task automatic test_nominal();
    int exp_lock[6] = '{0, 0, 0, 0, 1, 1};
    int n;
    run_tone(8, 5, 1'b0);
    @(posedge clk); #1;
    n = (q_per.size() < 6) ? q_per.size() : 6;
    checks++; if (q_per.size() != 6) begin failures++; $display("FAIL nominal_count got=%0d exp=6", q_per.size()); end
    checks++; if (n == 0 || q_smp[0] != 86) begin failures++; $display("FAIL nominal_first_sample got=%0d exp=86", (n == 0) ? -1 : q_smp[0]); end
    for (int i = 0; i < n; i++) begin
      checks++; if (q_per[i] != 40) begin failures++; $display("FAIL nominal_period[%0d] got=%0d exp=40", i, q_per[i]); end
      checks++; if (q_peak[i] != EXP_PEAK) begin failures++; $display("FAIL nominal_peak[%0d] got=%0d exp=%0d", i, q_peak[i], EXP_PEAK); end
      checks++; if (q_lock[i] != exp_lock[i]) begin failures++; $display("FAIL nominal_lock[%0d] got=%0d exp=%0d", i, q_lock[i], exp_lock[i]); end
      if (i > 0) begin
        checks++; if (q_cyc[i] - q_cyc[i-1] != 40) begin failures++; $display("FAIL nominal_gap[%0d] got=%0d exp=40", i, q_cyc[i] - q_cyc[i-1]); end
      end
    end
    checks++; if (period_out !== 16'd40 || locked_out !== 1'b1) begin failures++; $display("FAIL nominal_hold got=%0d/%0b exp=40/1", period_out, locked_out); end
    clear_log();
  endtask

  task automatic test_period_change();
    int exp_per[7]  = '{41, 48, 48, 48, 48, 48, 48};
    int exp_lock[7] = '{1, 0, 0, 0, 0, 1, 1};
    int n;
    run_tone(7, 6, 1'b0);
    @(posedge clk); #1;
    n = (q_per.size() < 7) ? q_per.size() : 7;
    checks++; if (q_per.size() != 7) begin failures++; $display("FAIL change_count got=%0d exp=7", q_per.size()); end
    for (int i = 0; i < n; i++) begin
      checks++; if (q_per[i] != exp_per[i]) begin failures++; $display("FAIL change_period[%0d] got=%0d exp=%0d", i, q_per[i], exp_per[i]); end
      checks++; if (q_lock[i] != exp_lock[i]) begin failures++; $display("FAIL change_lock[%0d] got=%0d exp=%0d", i, q_lock[i], exp_lock[i]); end
      checks++; if (q_peak[i] != EXP_PEAK) begin failures++; $display("FAIL change_peak[%0d] got=%0d exp=%0d", i, q_peak[i], EXP_PEAK); end
    end
    clear_log();
  endtask

  task automatic test_no_crossing();
    pulse_reset();
    for (int i = 0; i < 20; i++) drive(16'sd0, 1'b1);
    for (int p = 0; p < 10; p++) begin
      for (int h = 0; h < 5; h++) drive(16'sd1023, 1'b1);
      for (int h = 0; h < 5; h++) drive(-16'sd1023, 1'b1);
    end
    @(posedge clk); #1;
    checks++; if (q_per.size() != 0) begin failures++; $display("FAIL nocross_count got=%0d exp=0", q_per.size()); end
    checks++; if (locked_out !== 1'b0) begin failures++; $display("FAIL nocross_lock got=%0b exp=0", locked_out); end
    clear_log();
    for (int p = 0; p < 4; p++) begin
      for (int h = 0; h < 5; h++) drive(16'sd1024, 1'b1);
      for (int h = 0; h < 5; h++) drive(-16'sd1024, 1'b1);
    end
    @(posedge clk); #1;
    checks++; if (q_per.size() != 2) begin failures++; $display("FAIL thresh_count got=%0d exp=2", q_per.size()); end
    if (q_per.size() > 0) begin
      checks++; if (q_smp[0] != 21) begin failures++; $display("FAIL thresh_first_sample got=%0d exp=21", q_smp[0]); end
      checks++; if (q_per[0] != 10) begin failures++; $display("FAIL thresh_period got=%0d exp=10", q_per[0]); end
      checks++; if (q_peak[0] != SQ_PEAK) begin failures++; $display("FAIL thresh_peak got=%0d exp=%0d", q_peak[0], SQ_PEAK); end
    end
    checks++; if (locked_out !== 1'b0) begin failures++; $display("FAIL thresh_lock got=%0b exp=0", locked_out); end
  endtask

  task automatic test_sparse();
    int exp_lock[6] = '{0, 0, 0, 0, 1, 1};
    int n;
    pulse_reset();
    run_tone(8, 5, 1'b1);
    @(posedge clk); #1;
    n = (q_per.size() < 6) ? q_per.size() : 6;
    checks++; if (q_per.size() != 6) begin failures++; $display("FAIL sparse_count got=%0d exp=6", q_per.size()); end
    checks++; if (n == 0 || q_smp[0] != 86) begin failures++; $display("FAIL sparse_first_sample got=%0d exp=86", (n == 0) ? -1 : q_smp[0]); end
    for (int i = 0; i < n; i++) begin
      checks++; if (q_per[i] != 40) begin failures++; $display("FAIL sparse_period[%0d] got=%0d exp=40", i, q_per[i]); end
      checks++; if (q_lock[i] != exp_lock[i]) begin failures++; $display("FAIL sparse_lock[%0d] got=%0d exp=%0d", i, q_lock[i], exp_lock[i]); end
      if (i > 0) begin
        checks++; if (q_cyc[i] - q_cyc[i-1] != 80) begin failures++; $display("FAIL sparse_gap[%0d] got=%0d exp=80", i, q_cyc[i] - q_cyc[i-1]); end
      end
    end
    clear_log();
  endtask

  task automatic test_stall();
    for (int s = 1; s <= 65535; s++) begin
      drive(-16'sd2000, 1'b1);
      if (s == 60000) begin
        @(posedge clk); #1;
        checks++; if (locked_out !== 1'b1) begin failures++; $display("FAIL stall_early_lock got=%0b exp=1", locked_out); end
      end
    end
    @(posedge clk); #1;
    checks++; if (q_per.size() != 0) begin failures++; $display("FAIL stall_pulses got=%0d exp=0", q_per.size()); end
    checks++; if (locked_out !== 1'b0) begin failures++; $display("FAIL stall_lock got=%0b exp=0", locked_out); end
    clear_log();
    run_tone(3, 5, 1'b0);
    @(posedge clk); #1;
    checks++; if (q_per.size() != 2) begin failures++; $display("FAIL restart_count got=%0d exp=2", q_per.size()); end
    if (q_per.size() > 0) begin
      checks++; if (q_smp[0] != 46) begin failures++; $display("FAIL restart_first_sample got=%0d exp=46", q_smp[0]); end
      checks++; if (q_per[0] != 40) begin failures++; $display("FAIL restart_period got=%0d exp=40", q_per[0]); end
    end
    checks++; if (locked_out !== 1'b0) begin failures++; $display("FAIL restart_lock got=%0b exp=0", locked_out); end
    clear_log();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 4; k++)
      for (int h = 0; h < 5; h++) drive(sine[k], 1'b1);
    @(posedge clk); #1;
    checks++; if (period_out !== 16'd40) begin failures++; $display("FAIL premid_period got=%0d exp=40", period_out); end
    @(negedge clk); rst_in = 1'b1; sample_valid_in = 1'b1; data_in = 16'sh5A7E;
    @(posedge clk); #1;
    checks++; if (period_out !== 16'd0) begin failures++; $display("FAIL mid_period got=%0d exp=0", period_out); end
    checks++; if (peak_out !== 16'd0) begin failures++; $display("FAIL mid_peak got=%0d exp=0", peak_out); end
    checks++; if (measure_valid_out !== 1'b0) begin failures++; $display("FAIL mid_mv got=%0b exp=0", measure_valid_out); end
    checks++; if (locked_out !== 1'b0) begin failures++; $display("FAIL mid_lock got=%0b exp=0", locked_out); end
    @(negedge clk); rst_in = 1'b0; sample_valid_in = 1'b0;
    clear_log();
    run_tone(3, 5, 1'b0);
    @(posedge clk); #1;
    checks++; if (q_per.size() != 1) begin failures++; $display("FAIL resume_count got=%0d exp=1", q_per.size()); end
    if (q_per.size() > 0) begin
      checks++; if (q_smp[0] != 86) begin failures++; $display("FAIL resume_sample got=%0d exp=86", q_smp[0]); end
      checks++; if (q_per[0] != 40) begin failures++; $display("FAIL resume_period got=%0d exp=40", q_per[0]); end
      checks++; if (q_peak[0] != EXP_PEAK) begin failures++; $display("FAIL resume_peak got=%0d exp=%0d", q_peak[0], EXP_PEAK); end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_period_change();
    test_no_crossing();
    test_sparse();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tone_detector.md
# tone_detector

Receive-side companion to the on-chip sine test-tone generator. It consumes a stream of 16-bit signed samples and detects rising zero crossings with hysteresis. Per waveform period it reports the period length in samples and the peak absolute amplitude, and it asserts a lock flag once the period is stable. It sits on the sample path at the output of the tone source (or its loopback) and is the measurement point for self-test of that source.

## Interface
- `HYST`, 16'd1024: hysteresis threshold (positive). The high level is `>= +HYST`; the low level is `<= -HYST`.
- `PERIOD_W`, 16: width of the period counter and of `period_out`.
- `PERIOD_TOL`, 2: maximum absolute difference between consecutive periods that still counts as a match.
- `LOCK_COUNT`, 4: number of consecutive matches required to assert lock.

Ports:
- `clk` in 1: system clock.
- `rst_in` in 1: synchronous, active-high reset.
- `data_in` in 16 signed: input sample.
- `sample_valid_in` in 1: `data_in` is accepted on any edge where this is high. There is no backpressure.
- `period_out` out PERIOD_W: last measured period, in samples.
- `peak_out` out 16 unsigned: maximum |sample| over the last measured period.
- `measure_valid_out` out 1: one-cycle pulse when `period_out`/`peak_out` update.
- `locked_out` out 1: high while the period is stable.

## Operation
- FSM states: `SEEK_LOW`, `LOW`, `HIGH`.
  - `SEEK_LOW` → `LOW` on a valid sample `<= -HYST`.
  - `LOW` → `HIGH` on a valid sample `>= HYST`. This transition is a *rising event*.
  - `HIGH` → `LOW` on a valid sample `<= -HYST`.
  - All other valid samples leave the state unchanged. With `sample_valid_in` low, nothing changes.
- `have_ref` flag: cleared in `SEEK_LOW`, set on the first rising event. An event with `have_ref=0` only establishes the reference and produces no measurement.
- Sample counter `cnt`:
  - Set to 0 on the event sample.
  - +1 on every other valid sample.
  - At the next event, measured period = `cnt + 1`.
- Counter saturation: if `cnt` reaches 2^PERIOD_W−1 on a non-event sample, the block times out. It goes to `SEEK_LOW`, clears `have_ref`, clears the match count and `locked_out`, and emits no measurement. If saturation and an event occur on the same sample, the event wins and the measurement is emitted normally.
- Peak tracker:
  - Holds the running max of |x| over the valid samples since the last event, including the event sample itself.
  - At an event, the captured peak excludes the current event sample. The tracker is then reloaded with |event sample|.
  - |x| uses a 17-bit intermediate, so |−32768| = 32768 (16'h8000). The result is unsigned 16-bit.
- Lock:
  - Each measurement is compared with the previous measurement: |P − Pprev| ≤ PERIOD_TOL increments the match count (saturating at LOCK_COUNT); otherwise the match count is cleared and `locked_out` drops.
  - `locked_out` goes high when the match count reaches LOCK_COUNT.
  - The first measurement after reference establishment has no Pprev and counts as a mismatch.
- Comparisons are signed. Samples of exactly +HYST / −HYST count as crossing.

## Timing
- Reset values: `period_out`=0, `peak_out`=0, `measure_valid_out`=0, `locked_out`=0, state `SEEK_LOW`, `cnt`=0, `have_ref`=0, match count 0, tracker 0.
- All outputs are registered. Latency is 1 cycle: a sample accepted on edge N produces `measure_valid_out`/updated values visible after edge N, for exactly one cycle.
- `period_out`/`peak_out` hold their values between pulses.
- `locked_out` changes on the same edge as the `measure_valid_out` pulse that causes the change, or on a timeout.
- Reset mid-period: everything returns to reset values on the next edge. Two fresh rising events are needed before the next measurement.
- Throughput: one sample per cycle, sustained.

## Configuration
- `TONE_DET_PEAK_EN` defined: peak tracker and `peak_out` operate as described above.
- `TONE_DET_PEAK_EN` undefined: tracker logic is removed and `peak_out` is constant 0. Period, `measure_valid_out` and lock behaviour are unchanged.

## Structure
- Shared package `tone_det_pkg` contains:
  - State enum `tone_det_state_t` {SEEK_LOW, LOW, HIGH}.
  - `sample_t` (logic signed [15:0]).
  - Default `HYST` constant.
- Sub-module `tone_det_crossing` contains the hysteresis FSM and `have_ref`. It outputs the `rising_event` and `timeout_clear` strobes to the top-level, which holds the counter, peak and lock logic.

## Test plan
1. **Nominal tone.** Drive the 8-point sine (0, 5A7E, 7FFF, 5A7E, 0, A582, 8000, A582), each sample held 5 valid cycles, continuous, for 8 periods → `measure_valid_out` every 40 cycles starting at the 2nd event, `period_out`=40, `peak_out`=16'h8000, `locked_out` rising with the 6th event pulse.
2. **No crossing.** Constant 0, then a square wave between ±1023 → no `measure_valid_out`, `locked_out`=0. Step the amplitude to ±1024 → events begin.
3. **Sparse valid.** Same waveform as scenario 1 with `sample_valid_in` high every other cycle → `period_out`=40, pulses every 80 cycles.
4. **Period change.** After lock, switch to 6 cycles per sample (period 48) → `locked_out` drops on the first 48 measurement and reasserts after 4 matching 48s. A 40→41 jump keeps lock.
5. **Stall.** Hold −2000 for 65535 valid samples → timeout, no pulse, `locked_out`=0. Restart the tone → the first measurement comes at the 2nd event.
6. **Reset mid-period.** Assert `rst_in` for 1 cycle during a period → all outputs 0 on the next edge. Measurements resume after two events. With `TONE_DET_PEAK_EN` undefined, `peak_out` stays 0 throughout.
